rob_wb_arbiter: RTL and testbench
=================================

# rob_wb_arbiter

Writeback arbiter that shares a single ROB writeback port between the ALU and the load unit. Each source gets a small private queue, and a round-robin arbiter drains one entry per cycle into the ROB's write path. Branch NPC/mispredict information rides along with ALU entries. A flush on retire redirect empties both queues.

## Interface
Parameters:
- `DEPTH`, default 2: entries per source queue; must be ≥1, need not be a power of two.
- `CNT_WIDTH`, default 16: width of the saturating contention counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `alu_wb_valid`  in  1  ALU writeback request.
- `alu_wb_ready`  out  1  ALU queue can accept.
- `alu_wb_rob_id`  in  rob_id_t  destination ROB entry.
- `alu_wb_reg_data`  in  reg_data_t  result.
- `alu_npc_wb_valid`  in  1  entry carries a resolved branch NPC.
- `alu_npc_mispred`  in  1  branch mispredicted.
- `alu_npc`  in  addr_t  resolved next PC.
- `ld_wb_valid`  in  1  load writeback request.
- `ld_wb_ready`  out  1  load queue can accept.
- `ld_wb_rob_id`  in  rob_id_t  destination ROB entry.
- `ld_wb_reg_data`  in  reg_data_t  load data.
- `flush`  in  1  retire redirect; discard all queued writebacks.
- `rob_wb_valid`  out  1  write the ROB this cycle.
- `rob_wb_src`  out  1  0 = ALU, 1 = load.
- `rob_wb_rob_id`  out  rob_id_t  ROB entry.
- `rob_wb_reg_data`  out  reg_data_t  data.
- `rob_wb_npc_valid`  out  1  NPC field valid. Always 0 when `rob_wb_src` = 1.
- `rob_wb_mispred`  out  1  mispredict flag.
- `rob_wb_npc`  out  addr_t  next PC.
- `contention_cnt`  out  CNT_WIDTH  count of cycles in which both sources had a pending entry.

## Operation
- **Queues.** Each source has its own FIFO.
  - Enqueue on `*_wb_valid & *_wb_ready`.
  - `*_wb_ready` = (count < DEPTH) & ~flush. It is computed from registered count only, so a full queue does not accept even if it dequeues in the same cycle.
  - Read and write pointers wrap explicitly from DEPTH-1 to 0.
  - Count is `$clog2(DEPTH+1)` bits wide.
- **Arbitration.** Once per cycle, among the non-empty queue heads:
  - One candidate: grant it.
  - Two candidates: grant the source that is not `last_grant`.
  - `last_grant` updates on every grant. Reset value = load, so the ALU wins the first tie.
- **Output.** The output is the granted head, driven combinationally from queue state. The granted entry is dequeued at the same edge. The ROB always accepts, so there is no back-pressure on the output.
- **Flush.**
  - In the flush cycle, `rob_wb_valid` = 0 and both readies are 0.
  - At the edge, both counts and pointers clear.
  - `last_grant` and `contention_cnt` are unchanged.
  - A flush coinciding with a request drops that request.
- **Contention counter.** `contention_cnt` increments in each non-flush cycle in which both queues are non-empty. It saturates at all-ones and does not wrap.
- **Reset.**
  - Queues empty, `last_grant` = load, `contention_cnt` = 0.
  - All `rob_wb_*` outputs = 0.
  - Both readies = 0 while `rst` is high.
  - Reset mid-operation discards all queued entries.

## Timing
- Latency is 1 cycle when uncontended: an entry enqueued at edge N appears on `rob_wb_*` in cycle N+1. Latency is 0 with the bypass option (see Configuration).
- Throughput is one ROB write per cycle. Sustained dual-source traffic alternates ALU, load, ALU, and so on.
- With DEPTH=2 and both sources requesting every cycle, each source is throttled to half rate, and the readies toggle accordingly.
- Enqueue and dequeue on the same queue in the same cycle leave its count unchanged.
- `rob_wb_*` data fields are don't-care when `rob_wb_valid` = 0, but the implementation drives 0 in that case.

## Configuration
- `ROB_WB_ARB_BYPASS_EN` defined:
  - In any non-flush cycle where both queues are empty and exactly one source is requesting, its request goes combinationally to `rob_wb_*` in the same cycle and is not enqueued.
  - `last_grant` updates as for a normal grant.
  - If both sources request while both queues are empty, there is no bypass: both enqueue.
- `ROB_WB_ARB_BYPASS_EN` undefined: every writeback passes through its queue, and the minimum latency is 1 cycle.

## Structure
- **Shared package (global defs):**
  - `rob_wb_req_t` struct: `rob_id`, `reg_data`, `npc_valid`, `mispred`, `npc`.
  - `ROB_WB_SRC_ALU` = 0, `ROB_WB_SRC_LD` = 1.
- **Sub-module `wb_queue`:** a parameterised DEPTH-entry FIFO of `rob_wb_req_t` with count, ready, head and flush. It is instantiated twice; load entries tie the NPC fields to 0.
- **Arbiter, bypass and counter:** these stay in the top module.

## Test plan
- **Single ALU write.** Reset, then ALU wb with `rob_id` 5, data 0xDEAD, `npc_valid` 1, `mispred` 1, npc 0x1000 → next cycle `rob_wb_valid` = 1, src = 0, id 5, data 0xDEAD, npc fields match. With bypass: same cycle.
- **Tie then alternation.** Both sources request every cycle for 6 cycles → grants ALU, LD, ALU, LD, …; `contention_cnt` increments once per cycle both queues are non-empty; each ready is low when its queue holds 2 entries.
- **Fill and drain (DEPTH=2).** Load requests for 3 consecutive cycles while the ALU queue is kept busy → the third load sees `ld_wb_ready` = 0 until a load dequeues; no entry is lost or duplicated; pointer wrap is exercised.
- **Flush.** Both queues are full when `flush` pulses for one cycle → that cycle `rob_wb_valid` = 0 and readies = 0; next cycle queues are empty, `rob_wb_valid` = 0, and readies = 1.
- **Saturation and reset.** With `CNT_WIDTH` = 4, hold contention for 20 cycles → `contention_cnt` stays at 15. Assert `rst` mid-traffic → next cycle all outputs = 0 and the queues are empty.

Source files
------------

// File: rtl/rob_wb_arbiter_pkg.sv
// Shared types for the ROB writeback arbiter: request payload and source encoding.
package rob_wb_arbiter_pkg;

  localparam int ROB_ID_W   = 6;
  localparam int REG_DATA_W = 32;
  localparam int ADDR_W     = 32;

  typedef logic [ROB_ID_W-1:0]   rob_id_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [ADDR_W-1:0]     addr_t;

  typedef struct packed {
    rob_id_t   rob_id;
    reg_data_t reg_data;
    logic      npc_valid;
    logic      mispred;
    addr_t     npc;
  } rob_wb_req_t;

  localparam logic ROB_WB_SRC_ALU = 1'b0;
  localparam logic ROB_WB_SRC_LD  = 1'b1;

endpackage

// File: rtl/rob_wb_arbiter_wb_queue.sv
// Per-source writeback FIFO: DEPTH entries (any DEPTH >= 1), explicit pointer wrap,
// readiness taken from the registered count only, flush clears at the edge.
module rob_wb_arbiter_wb_queue
  import rob_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push_valid,
  input  rob_wb_req_t push_req,
  input  logic        pop,
  output logic        ready,
  output logic        not_empty,
  output rob_wb_req_t head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  rob_wb_req_t   mem [DEPTH];
  logic          push;
  logic          pull;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready     = ~rst & ~flush & (count < CW'(DEPTH));
  assign not_empty = (count != '0);
  assign push      = push_valid & ready;
  assign pull      = pop & not_empty;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pull) rd_ptr <= next_ptr(rd_ptr);
      if (push && !pull)      count <= count + 1'b1;
      else if (pull && !push) count <= count - 1'b1;
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Shares one ROB writeback port between ALU and load queues with round-robin grant.
// Optional same-cycle bypass into an idle port: define ROB_WB_ARB_BYPASS_EN.
module rob_wb_arbiter
  import rob_wb_arbiter_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_wb_valid,
  output logic                 alu_wb_ready,
  input  rob_id_t              alu_wb_rob_id,
  input  reg_data_t            alu_wb_reg_data,
  input  logic                 alu_npc_wb_valid,
  input  logic                 alu_npc_mispred,
  input  addr_t                alu_npc,
  input  logic                 ld_wb_valid,
  output logic                 ld_wb_ready,
  input  rob_id_t              ld_wb_rob_id,
  input  reg_data_t            ld_wb_reg_data,
  input  logic                 flush,
  output logic                 rob_wb_valid,
  output logic                 rob_wb_src,
  output rob_id_t              rob_wb_rob_id,
  output reg_data_t            rob_wb_reg_data,
  output logic                 rob_wb_npc_valid,
  output logic                 rob_wb_mispred,
  output addr_t                rob_wb_npc,
  output logic [CNT_WIDTH-1:0] contention_cnt
);

  rob_wb_req_t alu_req, ld_req, alu_head, ld_head, grant_req;
  logic        alu_ne, ld_ne, alu_pop, ld_pop;
  logic        byp_alu, byp_ld;
  logic        grant_valid, grant_src, last_grant;

  assign alu_req = '{rob_id: alu_wb_rob_id, reg_data: alu_wb_reg_data,
                     npc_valid: alu_npc_wb_valid, mispred: alu_npc_mispred, npc: alu_npc};
  assign ld_req  = '{rob_id: ld_wb_rob_id, reg_data: ld_wb_reg_data,
                     npc_valid: 1'b0, mispred: 1'b0, npc: '0};

  rob_wb_arbiter_wb_queue #(.DEPTH(DEPTH)) u_alu_q (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(alu_wb_valid & ~byp_alu), .push_req(alu_req), .pop(alu_pop),
    .ready(alu_wb_ready), .not_empty(alu_ne), .head(alu_head)
  );

  rob_wb_arbiter_wb_queue #(.DEPTH(DEPTH)) u_ld_q (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(ld_wb_valid & ~byp_ld), .push_req(ld_req), .pop(ld_pop),
    .ready(ld_wb_ready), .not_empty(ld_ne), .head(ld_head)
  );

  always_comb begin
    grant_valid = 1'b0;
    grant_src   = ROB_WB_SRC_ALU;
    byp_alu     = 1'b0;
    byp_ld      = 1'b0;
    alu_pop     = 1'b0;
    ld_pop      = 1'b0;
    if (!rst && !flush) begin
      if (alu_ne && ld_ne) begin
        grant_valid = 1'b1;
        grant_src   = ~last_grant;
      end else if (alu_ne) begin
        grant_valid = 1'b1;
        grant_src   = ROB_WB_SRC_ALU;
      end else if (ld_ne) begin
        grant_valid = 1'b1;
        grant_src   = ROB_WB_SRC_LD;
      end
`ifdef ROB_WB_ARB_BYPASS_EN
      // Both queues idle and a lone requester: hand it straight to the ROB.
      else if (alu_wb_valid ^ ld_wb_valid) begin
        grant_valid = 1'b1;
        grant_src   = ld_wb_valid ? ROB_WB_SRC_LD : ROB_WB_SRC_ALU;
        byp_alu     = alu_wb_valid;
        byp_ld      = ld_wb_valid;
      end
`endif
      alu_pop = grant_valid && (grant_src == ROB_WB_SRC_ALU) && !byp_alu;
      ld_pop  = grant_valid && (grant_src == ROB_WB_SRC_LD) && !byp_ld;
    end
  end

  always_comb begin
    grant_req = alu_head;
    if (byp_alu)                          grant_req = alu_req;
    else if (byp_ld)                      grant_req = ld_req;
    else if (grant_src == ROB_WB_SRC_LD)  grant_req = ld_head;

    rob_wb_valid     = grant_valid;
    rob_wb_src       = ROB_WB_SRC_ALU;
    rob_wb_rob_id    = '0;
    rob_wb_reg_data  = '0;
    rob_wb_npc_valid = 1'b0;
    rob_wb_mispred   = 1'b0;
    rob_wb_npc       = '0;
    if (grant_valid) begin
      rob_wb_src       = grant_src;
      rob_wb_rob_id    = grant_req.rob_id;
      rob_wb_reg_data  = grant_req.reg_data;
      rob_wb_npc_valid = grant_req.npc_valid;
      rob_wb_mispred   = grant_req.mispred;
      rob_wb_npc       = grant_req.npc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant     <= ROB_WB_SRC_LD;
      contention_cnt <= '0;
    end else begin
      if (grant_valid) last_grant <= grant_src;
      if (!flush && alu_ne && ld_ne && (contention_cnt != '1))
        contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter; expected writebacks queued in a scoreboard
// and popped by an independent output monitor.
module tb_rob_wb_arbiter;
  import rob_wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk, rst, flush;
  logic alu_wb_valid, alu_wb_ready, alu_npc_wb_valid, alu_npc_mispred;
  rob_id_t alu_wb_rob_id, ld_wb_rob_id, rob_wb_rob_id;
  reg_data_t alu_wb_reg_data, ld_wb_reg_data, rob_wb_reg_data;
  addr_t alu_npc, rob_wb_npc;
  logic ld_wb_valid, ld_wb_ready;
  logic rob_wb_valid, rob_wb_src, rob_wb_npc_valid, rob_wb_mispred;
  logic [CNT_W-1:0] contention_cnt;

  rob_wb_arbiter #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_rob_id(alu_wb_rob_id), .alu_wb_reg_data(alu_wb_reg_data),
    .alu_npc_wb_valid(alu_npc_wb_valid), .alu_npc_mispred(alu_npc_mispred), .alu_npc(alu_npc),
    .ld_wb_valid(ld_wb_valid), .ld_wb_ready(ld_wb_ready),
    .ld_wb_rob_id(ld_wb_rob_id), .ld_wb_reg_data(ld_wb_reg_data),
    .flush(flush),
    .rob_wb_valid(rob_wb_valid), .rob_wb_src(rob_wb_src), .rob_wb_rob_id(rob_wb_rob_id),
    .rob_wb_reg_data(rob_wb_reg_data), .rob_wb_npc_valid(rob_wb_npc_valid),
    .rob_wb_mispred(rob_wb_mispred), .rob_wb_npc(rob_wb_npc),
    .contention_cnt(contention_cnt)
  );

  typedef struct packed {
    logic        src;
    rob_wb_req_t req;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [$bits(exp_t)-1:0] mon_act;
  int   checks = 0;
  int   errors = 0;
  logic sb_off = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rob_wb_req_t alu_item(input int i);
    rob_wb_req_t r;
    r.rob_id    = rob_id_t'(i);
    r.reg_data  = reg_data_t'(32'hA000_0000 + i);
    r.npc_valid = i[0];
    r.mispred   = i[1];
    r.npc       = addr_t'(32'h0000_2000 + 4 * i);
    return r;
  endfunction

  function automatic rob_wb_req_t ld_item(input int i);
    rob_wb_req_t r;
    r.rob_id    = rob_id_t'(16 + i);
    r.reg_data  = reg_data_t'(32'hB000_0000 + i);
    r.npc_valid = 1'b0;
    r.mispred   = 1'b0;
    r.npc       = '0;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp_alu(input int i);
    exp_t e;
    e.src = ROB_WB_SRC_ALU;
    e.req = alu_item(i);
    sb.push_back(e);
  endtask

  task automatic exp_ld(input int i);
    exp_t e;
    e.src = ROB_WB_SRC_LD;
    e.req = ld_item(i);
    sb.push_back(e);
  endtask

  task automatic set_alu(input logic v, input int i);
    rob_wb_req_t r;
    r = alu_item(i);
    alu_wb_valid     = v;
    alu_wb_rob_id    = r.rob_id;
    alu_wb_reg_data  = r.reg_data;
    alu_npc_wb_valid = r.npc_valid;
    alu_npc_mispred  = r.mispred;
    alu_npc          = r.npc;
  endtask

  task automatic set_ld(input logic v, input int i);
    rob_wb_req_t r;
    r = ld_item(i);
    ld_wb_valid    = v;
    ld_wb_rob_id   = r.rob_id;
    ld_wb_reg_data = r.reg_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cycle(input logic av, input int ai, input logic lv, input int li,
                          input logic ar, input logic lr);
    tick();
    set_alu(av, ai);
    set_ld(lv, li);
    @(negedge clk);
    check("alu_ready", 64'(alu_wb_ready), 64'(ar));
    check("ld_ready", 64'(ld_wb_ready), 64'(lr));
  endtask

  task automatic idle_cycle();
    tick();
    set_alu(1'b0, 0);
    set_ld(1'b0, 0);
    @(negedge clk);
  endtask

  // Output monitor: every presented writeback must match the next expected entry.
  always @(negedge clk) begin
    if (!sb_off && rob_wb_valid) begin
      checks++;
      mon_act = {rob_wb_src, rob_wb_rob_id, rob_wb_reg_data, rob_wb_npc_valid,
                 rob_wb_mispred, rob_wb_npc};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h, required no writeback (t=%0t)", mon_act, $time);
      end else begin
        mon_e = sb.pop_front();
        if (mon_act !== mon_e) begin
          errors++;
          $display("FAIL sb_entry: got %h, required %h (t=%0t)", mon_act, mon_e, $time);
        end
      end
    end
  end

  int   t2_aid[6] = '{0, 1, 2, 3, 3, 4};
  int   t2_lid[6] = '{0, 1, 2, 2, 3, 3};
  logic t2_ar[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic t2_lr[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int   t2_cnt[6] = '{0, 0, 1, 2, 3, 4};

  int   t3_aid[4] = '{10, 11, 12, 13};
  int   t3_lid[4] = '{10, 11, 12, 12};
  logic t3_ar[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic t3_lr[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    set_alu(1'b0, 0);
    set_ld(1'b0, 0);
    tick();
    tick();
    @(negedge clk);
    check("rst_alu_ready", 64'(alu_wb_ready), 64'(0));
    check("rst_ld_ready", 64'(ld_wb_ready), 64'(0));
    check("rst_valid", 64'(rob_wb_valid), 64'(0));
    check("rst_cnt", 64'(contention_cnt), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_alu_ready", 64'(alu_wb_ready), 64'(1));
    check("post_rst_ld_ready", 64'(ld_wb_ready), 64'(1));
    check("post_rst_valid", 64'(rob_wb_valid), 64'(0));

    // Tie and alternation: ALU wins the first tie, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      exp_alu(i);
      exp_ld(i);
    end
    for (int k = 0; k < 6; k++) begin
      do_cycle(1'b1, t2_aid[k], 1'b1, t2_lid[k], t2_ar[k], t2_lr[k]);
      check("t2_cnt", 64'(contention_cnt), 64'(t2_cnt[k]));
    end
    repeat (4) idle_cycle();
    check("t2_cnt_final", 64'(contention_cnt), 64'(7));
    check("t2_idle_valid", 64'(rob_wb_valid), 64'(0));

    // Fill and drain with load pointer wrap; third load stalls one cycle.
    for (int i = 10; i < 13; i++) begin
      exp_alu(i);
      exp_ld(i);
    end
    for (int k = 0; k < 4; k++)
      do_cycle(1'b1, t3_aid[k], 1'b1, t3_lid[k], t3_ar[k], t3_lr[k]);
    repeat (4) idle_cycle();
    check("t3_cnt_final", 64'(contention_cnt), 64'(12));

    // Single ALU write with branch info.
    begin
      exp_t e;
      e.src = ROB_WB_SRC_ALU;
      e.req = '{rob_id: rob_id_t'(5), reg_data: reg_data_t'(32'hDEAD), npc_valid: 1'b1,
                mispred: 1'b1, npc: addr_t'(32'h1000)};
      sb.push_back(e);
    end
    tick();
    alu_wb_valid = 1'b1;
    alu_wb_rob_id = rob_id_t'(5);
    alu_wb_reg_data = reg_data_t'(32'hDEAD);
    alu_npc_wb_valid = 1'b1;
    alu_npc_mispred = 1'b1;
    alu_npc = addr_t'(32'h1000);
    @(negedge clk);
`ifdef ROB_WB_ARB_BYPASS_EN
    check("t1_same_cycle_valid", 64'(rob_wb_valid), 64'(1));
`else
    check("t1_same_cycle_valid", 64'(rob_wb_valid), 64'(0));
`endif
    idle_cycle();
`ifdef ROB_WB_ARB_BYPASS_EN
    check("t1_next_cycle_valid", 64'(rob_wb_valid), 64'(0));
`else
    check("t1_next_cycle_valid", 64'(rob_wb_valid), 64'(1));
`endif
    idle_cycle();
    check("t1_idle_valid", 64'(rob_wb_valid), 64'(0));
    check("t1_idle_data", 64'(rob_wb_reg_data), 64'(0));
    check("t1_idle_npc", 64'(rob_wb_npc), 64'(0));

    // Flush with ALU queue full and one load pending; ALU then wins the next tie.
    exp_ld(20);
    exp_alu(23);
    exp_ld(23);
    do_cycle(1'b1, 20, 1'b1, 20, 1'b1, 1'b1);
    do_cycle(1'b1, 21, 1'b1, 21, 1'b1, 1'b1);
    tick();
    set_alu(1'b1, 22);
    set_ld(1'b1, 22);
    flush = 1'b1;
    @(negedge clk);
    check("flush_valid", 64'(rob_wb_valid), 64'(0));
    check("flush_alu_ready", 64'(alu_wb_ready), 64'(0));
    check("flush_ld_ready", 64'(ld_wb_ready), 64'(0));
    check("flush_cnt", 64'(contention_cnt), 64'(13));
    tick();
    flush = 1'b0;
    set_alu(1'b0, 0);
    set_ld(1'b0, 0);
    @(negedge clk);
    check("post_flush_valid", 64'(rob_wb_valid), 64'(0));
    check("post_flush_alu_ready", 64'(alu_wb_ready), 64'(1));
    check("post_flush_ld_ready", 64'(ld_wb_ready), 64'(1));
    check("post_flush_cnt", 64'(contention_cnt), 64'(13));
    do_cycle(1'b1, 23, 1'b1, 23, 1'b1, 1'b1);
    repeat (3) idle_cycle();
    check("t4_cnt_final", 64'(contention_cnt), 64'(14));
    check("sb_drained", 64'(sb.size()), 64'(0));

    // Saturation under continuous contention, then reset mid-traffic.
    sb_off = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      set_alu(1'b1, 1);
      set_ld(1'b1, 1);
      @(negedge clk);
      if (k >= 2) check("sat_cnt", 64'(contention_cnt), 64'(15));
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_alu_ready", 64'(alu_wb_ready), 64'(0));
    check("mid_rst_ld_ready", 64'(ld_wb_ready), 64'(0));
    check("mid_rst_valid", 64'(rob_wb_valid), 64'(0));
    tick();
    rst = 1'b0;
    sb_off = 1'b0;
    set_alu(1'b0, 0);
    set_ld(1'b0, 0);
    @(negedge clk);
    check("after_rst_valid", 64'(rob_wb_valid), 64'(0));
    check("after_rst_outputs",
          64'({rob_wb_src, rob_wb_rob_id, rob_wb_npc_valid, rob_wb_mispred}), 64'(0));
    check("after_rst_data", 64'(rob_wb_reg_data), 64'(0));
    check("after_rst_npc", 64'(rob_wb_npc), 64'(0));
    check("after_rst_cnt", 64'(contention_cnt), 64'(0));
    check("after_rst_alu_ready", 64'(alu_wb_ready), 64'(1));
    check("after_rst_ld_ready", 64'(ld_wb_ready), 64'(1));
    idle_cycle();
    check("after_rst_empty", 64'(rob_wb_valid), 64'(0));
    check("sb_final", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
